// File: rtl/grn_output_packer_pkg.sv
// Shared definitions for the GRN output path: packer FSM states and the
// default entry/word widths used by the arbiter, FIFO and packer.
package grn_output_packer_pkg;

   localparam int IN_WIDTH_DEF  = 32;
   localparam int OUT_WIDTH_DEF = 512;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/grn_output_packer_if.sv
// Packed-word stream from the output packer to the host/DMA writer.
// master: out_valid/out_data/out_last out, out_ready in; slave: reverse.
interface grn_output_packer_if
   import grn_output_packer_pkg::*;
#(
   parameter int OUT_WIDTH = OUT_WIDTH_DEF
) ();

   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/grn_output_packer.sv
// Drains fifo_out and packs OUT_WIDTH/IN_WIDTH entries per output word;
// on flush emits the zero-padded partial word tagged last, then done.
// Ports: clk, rst (sync, high), start (0 = soft clear), flush,
//   fifo_out_empty/fifo_out_data in, fifo_out_rd_en out,
//   out_if (master: valid/ready/data/last), out_words, done.
module grn_output_packer
   import grn_output_packer_pkg::*;
#(
   parameter int IN_WIDTH  = IN_WIDTH_DEF,
   parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                flush,
   input  logic                fifo_out_empty,
   input  logic [IN_WIDTH-1:0] fifo_out_data,
   output logic                fifo_out_rd_en,
   grn_output_packer_if.master out_if,
   output logic [31:0]         out_words,
   output logic                done
);

   localparam int RATIO = OUT_WIDTH / IN_WIDTH;
   localparam int LW    = $clog2(RATIO) + 1;
   localparam int BW    = $clog2(OUT_WIDTH);

   state_t               r_state;
   logic [OUT_WIDTH-1:0] r_buf;
   logic [LW-1:0]        r_lane_cnt;
   logic                 r_inflight;
   logic                 r_flush_seen;
   logic                 r_valid;
   logic                 r_last;
   logic                 r_done;
   logic [31:0]          r_words;

   logic [LW:0]          w_occupied;
   logic [LW-1:0]        w_lane_nxt;
   logic [BW-1:0]        w_lsb;
   logic                 w_rd_en;
   logic                 w_drained;

   // Count the read already in flight so a full word never over-reads.
   assign w_occupied = {1'b0, r_lane_cnt}
                     + {{LW{1'b0}}, r_inflight};
   assign w_rd_en    = (r_state == ST_FILL)
                     && !fifo_out_empty
                     && (w_occupied < (LW+1)'(RATIO));
   assign w_lane_nxt = r_lane_cnt + LW'(1);
   assign w_lsb      = BW'(r_lane_cnt) * BW'(IN_WIDTH);
   assign w_drained  = r_flush_seen && fifo_out_empty
                     && !r_inflight;

   always_ff @(posedge clk) begin
      if (rst || !start) begin
         r_state      <= ST_IDLE;
         r_buf        <= '0;
         r_lane_cnt   <= '0;
         r_inflight   <= 1'b0;
         r_flush_seen <= 1'b0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_done       <= 1'b0;
         r_words      <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (flush)
            r_flush_seen <= 1'b1;
         unique case (r_state)
            ST_IDLE: r_state <= ST_FILL;
            ST_FILL: begin
               if (r_inflight) begin
                  r_buf[w_lsb +: IN_WIDTH] <= fifo_out_data;
                  r_lane_cnt <= w_lane_nxt;
                  // A full word is never the tagged last one.
                  if (w_lane_nxt == LW'(RATIO)) begin
                     r_state <= ST_SEND;
                     r_valid <= 1'b1;
                     r_last  <= 1'b0;
                  end
               end else if (w_drained) begin
                  if (r_lane_cnt != '0) begin
                     r_state <= ST_SEND;
                     r_valid <= 1'b1;
                     r_last  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (out_if.out_ready) begin
                  r_valid    <= 1'b0;
                  r_last     <= 1'b0;
                  r_buf      <= '0;
                  r_lane_cnt <= '0;
                  r_words    <= r_words + 32'd1;
                  if (r_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_FILL;
                  end
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fifo_out_rd_en   = w_rd_en;
   assign out_if.out_valid = r_valid;
   assign out_if.out_data  = r_buf;
   assign out_if.out_last  = r_last;
   assign out_words        = r_words;
   assign done             = r_done;

endmodule

// File: tb/tb_grn_output_packer.sv
// Scoreboard bench for grn_output_packer: FIFO model, directed runs,
// negedge monitor comparing every handshaken word against expectations.
module tb_grn_output_packer;
   import grn_output_packer_pkg::*;

   localparam int IW = 32;
   localparam int OW = 512;

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          flush;
   logic          fifo_empty;
   logic [IW-1:0] fifo_data;
   logic          rd_en;
   logic [31:0]   out_words;
   logic          done;

   grn_output_packer_if #(.OUT_WIDTH(OW)) bus ();

   grn_output_packer #(
      .IN_WIDTH (IW),
      .OUT_WIDTH(OW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .flush         (flush),
      .fifo_out_empty(fifo_empty),
      .fifo_out_data (fifo_data),
      .fifo_out_rd_en(rd_en),
      .out_if        (bus),
      .out_words     (out_words),
      .done          (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   exp_t exp_q[$];
   exp_t e_pop;

   logic [IW-1:0] mem [0:511];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic rd_en_s = 1'b0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   task automatic check(input string name,
                        input logic [OW-1:0] act,
                        input logic [OW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // FIFO model: pop decided from rd_en sampled at the previous negedge.
   always @(posedge clk) begin
      if (rd_en_s) begin
         check("pop_nonempty", OW'(wr_ptr != rd_ptr), OW'(1));
         if (wr_ptr != rd_ptr) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
         end
      end
   end

   logic [OW-1:0] hold_data;
   logic          hold_last;
   logic          hold_pend = 1'b0;

   always @(negedge clk) begin
      rd_en_s = rd_en;
      if (bus.out_valid) begin
         check("rd_en_in_send", OW'(rd_en), OW'(0));
         if (hold_pend) begin
            check("stall_data", bus.out_data, hold_data);
            check("stall_last", OW'(bus.out_last), OW'(hold_last));
         end
         if (bus.out_ready) begin
            hold_pend = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h last=%0b want none",
                        bus.out_data, bus.out_last);
            end else begin
               e_pop = exp_q.pop_front();
               check("word_data", bus.out_data, e_pop.data);
               check("word_last", OW'(bus.out_last), OW'(e_pop.last));
            end
         end else begin
            hold_pend = 1'b1;
            hold_data = bus.out_data;
            hold_last = bus.out_last;
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [IW-1:0] v);
      mem[wr_ptr % 512] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic push_seq(input logic [IW-1:0] base, input int n);
      for (int k = 0; k < n; k++)
         push(base + IW'(k));
   endtask

   task automatic expect_word(input logic [IW-1:0] base,
                              input int n, input logic last);
      exp_t e;
      e.data = '0;
      for (int k = 0; k < n; k++)
         e.data[k*IW +: IW] = base + IW'(k);
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic wait_drained(input string name, input int lim);
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < lim) begin
         tick();
         n++;
      end
      check(name, OW'(exp_q.size()), OW'(0));
   endtask

   task automatic wait_done(input string name, input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      check(name, OW'(done), OW'(1));
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic stop_run();
      start = 1'b0;
      tick();
      tick();
      check("clear_words", OW'(out_words), OW'(0));
      check("clear_done", OW'(done), OW'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, OW'(bus.out_valid), OW'(0));
      check({tag, "_last"}, OW'(bus.out_last), OW'(0));
      check({tag, "_data"}, bus.out_data, OW'(0));
      check({tag, "_words"}, OW'(out_words), OW'(0));
      check({tag, "_done"}, OW'(done), OW'(0));
      check({tag, "_rd_en"}, OW'(rd_en), OW'(0));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      fifo_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // One full word, no flush.
      start = 1'b1;
      push_seq(32'h00, 16);
      expect_word(32'h00, 16, 1'b0);
      wait_drained("t1_drain", 100);
      check("t1_words", OW'(out_words), OW'(1));
      check("t1_not_done", OW'(done), OW'(0));
      stop_run();

      // Full word plus 4-lane partial tagged last.
      start = 1'b1;
      push_seq(32'h10, 20);
      expect_word(32'h10, 16, 1'b0);
      expect_word(32'h20, 4, 1'b1);
      pulse_flush();
      wait_done("t2_done", 200);
      wait_drained("t2_drain", 10);
      check("t2_words", OW'(out_words), OW'(2));
      stop_run();

      // Backpressure on the first word, 40 entries then flush.
      bus.out_ready = 1'b0;
      start = 1'b1;
      push_seq(32'h100, 40);
      expect_word(32'h100, 16, 1'b0);
      expect_word(32'h110, 16, 1'b0);
      expect_word(32'h120, 8, 1'b1);
      pulse_flush();
      n = 0;
      while (!bus.out_valid && n < 200) begin
         tick();
         n++;
      end
      check("t3_first_valid", OW'(bus.out_valid), OW'(1));
      repeat (10) tick();
      bus.out_ready = 1'b1;
      wait_done("t3_done", 300);
      wait_drained("t3_drain", 10);
      check("t3_words", OW'(out_words), OW'(3));
      stop_run();

      // Flush with nothing buffered: no word at all.
      start = 1'b1;
      repeat (3) tick();
      pulse_flush();
      wait_done("t4_done", 50);
      check("t4_words", OW'(out_words), OW'(0));
      check("t4_no_valid", OW'(bus.out_valid), OW'(0));
      stop_run();

      // Reset mid-word discards the partial buffer.
      start = 1'b1;
      push_seq(32'h50, 7);
      repeat (15) tick();
      rst = 1'b1;
      tick();
      check_all_zero("t5_rst");
      rst = 1'b0;
      push_seq(32'hA0, 16);
      expect_word(32'hA0, 16, 1'b0);
      wait_drained("t5_drain", 100);
      check("t5_words", OW'(out_words), OW'(1));
      stop_run();

      // Exact multiple at flush: two unlast words, straight to done.
      start = 1'b1;
      push_seq(32'hC0, 32);
      expect_word(32'hC0, 16, 1'b0);
      expect_word(32'hD0, 16, 1'b0);
      pulse_flush();
      wait_done("t6_done", 200);
      repeat (5) tick();
      check("t6_drain", OW'(exp_q.size()), OW'(0));
      check("t6_words", OW'(out_words), OW'(2));
      check("t6_hold_done", OW'(done), OW'(1));
      check("fifo_all_popped", OW'(rd_ptr), OW'(wr_ptr));
      stop_run();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
